// File: rtl/pe_array_drain.sv
// Output-stationary ROWS x COLS MAC array with a ready/valid beat input and a
// row-serial requantised drain, one COLS-wide row per output handshake.
module pe_array_drain #(
  parameter int ROWS              = 16,
  parameter int COLS              = 16,
  parameter int A_WIDTH           = 8,
  parameter int B_WIDTH           = 8,
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int OUTPUT_WIDTH      = 8,
  parameter int OUTPUT_SCALE      = 0
) (
  input  logic                            clk,
  input  logic                            arst_n_in,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  input  logic                            accumulate_internal,
  input  logic [ROWS*A_WIDTH-1:0]         activations,
  input  logic [COLS*B_WIDTH-1:0]         weights,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [COLS*OUTPUT_WIDTH-1:0]    out_row,
  output logic [$clog2(ROWS)-1:0]         out_row_idx,
  output logic                            out_last,
  output logic                            busy
);

  localparam int IDX_W = $clog2(ROWS);
  localparam int ACC_W = ACCUMULATOR_WIDTH;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
  localparam logic signed [ACC_W-1:0] ONE_ACC = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] OUT_MAX = (ONE_ACC <<< (OUTPUT_WIDTH - 1)) - ONE_ACC;
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t                    state_r, state_s;
  logic [IDX_W-1:0]          row_ptr_r, row_ptr_s;
  logic signed [ACC_W-1:0]   acc_r  [ROWS][COLS];
  logic signed [ACC_W-1:0]   prod_s [ROWS][COLS];
  logic signed [A_WIDTH-1:0] a_s    [ROWS];
  logic signed [B_WIDTH-1:0] b_s    [COLS];
  logic                      accept_s;
  logic [COLS*OUTPUT_WIDTH-1:0] out_row_s;

  // Arithmetic shift (floor) followed by saturation to the signed output range.
  function automatic logic [OUTPUT_WIDTH-1:0] requant(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] sh;
    sh = x >>> OUTPUT_SCALE;
    if (sh > OUT_MAX) begin
      return OUT_MAX[OUTPUT_WIDTH-1:0];
    end else if (sh < OUT_MIN) begin
      return OUT_MIN[OUTPUT_WIDTH-1:0];
    end else begin
      return sh[OUTPUT_WIDTH-1:0];
    end
  endfunction

  for (genvar r = 0; r < ROWS; r++) begin : g_act
    assign a_s[r] = activations[(ROWS-1-r)*A_WIDTH +: A_WIDTH];
  end
  for (genvar c = 0; c < COLS; c++) begin : g_wgt
    assign b_s[c] = weights[(COLS-1-c)*B_WIDTH +: B_WIDTH];
  end

  assign accept_s = in_valid && (state_r == ST_ACCUM);

  // Outer-product terms; sign-extending before the multiply keeps the
  // full-precision product exact since ACC_W >= A_WIDTH+B_WIDTH.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        prod_s[r][c] = ACC_W'(a_s[r]) * ACC_W'(b_s[c]);
      end
    end
  end

  // Accumulator bank: overwrite or accumulate on every accepted beat.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          acc_r[r][c] <= '0;
        end
      end
    end else if (accept_s) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          acc_r[r][c] <= (accumulate_internal ? acc_r[r][c] : '0) + prod_s[r][c];
        end
      end
    end
  end

  // State and drain pointer registers.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_r   <= ST_ACCUM;
      row_ptr_r <= '0;
    end else begin
      state_r   <= state_s;
      row_ptr_r <= row_ptr_s;
    end
  end

  // Next-state: enter drain on the last accepted beat, step rows on handshakes.
  always_comb begin
    state_s   = state_r;
    row_ptr_s = row_ptr_r;
    case (state_r)
      ST_ACCUM: begin
        if (accept_s && in_last) begin
          state_s   = ST_DRAIN;
          row_ptr_s = '0;
        end else begin
          state_s   = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (row_ptr_r == LAST_ROW) begin
            state_s   = ST_ACCUM;
            row_ptr_s = '0;
          end else begin
            row_ptr_s = row_ptr_r + IDX_W'(1);
          end
        end else begin
          row_ptr_s = row_ptr_r;
        end
      end
      default: begin
        state_s   = ST_ACCUM;
        row_ptr_s = '0;
      end
    endcase
  end

  // Drained row, held at zero outside the drain so reset/idle shows a clean bus.
  always_comb begin
    out_row_s = '0;
    if (state_r == ST_DRAIN) begin
      for (int c = 0; c < COLS; c++) begin
        out_row_s[(COLS-1-c)*OUTPUT_WIDTH +: OUTPUT_WIDTH] = requant(acc_r[row_ptr_r][c]);
      end
    end else begin
      out_row_s = '0;
    end
  end

  assign in_ready    = (state_r == ST_ACCUM);
  assign out_valid   = (state_r == ST_DRAIN);
  assign busy        = (state_r == ST_DRAIN);
  assign out_row_idx = row_ptr_r;
  assign out_last    = (state_r == ST_DRAIN) && (row_ptr_r == LAST_ROW);
  assign out_row     = out_row_s;

endmodule

// File: tb/tb_pe_array_drain.sv
// Bench for pe_array_drain: 4x4 arrays at scale 0 and scale 2 fed in parallel,
// model-based scoreboard of drained rows plus directed constant checks.
module tb_pe_array_drain;

  localparam int R = 4;
  localparam int C = 4;

  logic clk = 1'b0;
  logic arst_n_in, in_valid, in_last, accumulate_internal, out_ready;
  logic [R*8-1:0] activations;
  logic [C*8-1:0] weights;
  logic in_ready, out_valid, out_last, busy;
  logic in_ready2, out_valid2, out_last2, busy2;
  logic [C*8-1:0] out_row, out_row2;
  logic [1:0] out_row_idx, out_row_idx2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] row0;
    logic [31:0] row2;
    logic        last;
  } exp_t;

  exp_t q[$];
  logic signed [31:0] acc_m [R][C];
  logic [31:0] got0 [R];
  logic [31:0] got2 [R];

  always #5 clk = ~clk;

  pe_array_drain #(.ROWS(R), .COLS(C), .A_WIDTH(8), .B_WIDTH(8),
                   .ACCUMULATOR_WIDTH(32), .OUTPUT_WIDTH(8), .OUTPUT_SCALE(0)) dut (
    .clk(clk), .arst_n_in(arst_n_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .accumulate_internal(accumulate_internal),
    .activations(activations), .weights(weights), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_row_idx(out_row_idx),
    .out_last(out_last), .busy(busy));

  pe_array_drain #(.ROWS(R), .COLS(C), .A_WIDTH(8), .B_WIDTH(8),
                   .ACCUMULATOR_WIDTH(32), .OUTPUT_WIDTH(8), .OUTPUT_SCALE(2)) dut_s2 (
    .clk(clk), .arst_n_in(arst_n_in), .in_valid(in_valid), .in_ready(in_ready2),
    .in_last(in_last), .accumulate_internal(accumulate_internal),
    .activations(activations), .weights(weights), .out_valid(out_valid2),
    .out_ready(out_ready), .out_row(out_row2), .out_row_idx(out_row_idx2),
    .out_last(out_last2), .busy(busy2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rq(input logic signed [31:0] x, input int sh);
    logic signed [31:0] y;
    y = x >>> sh;
    if (y > 127) return 8'h7f;
    if (y < -128) return 8'h80;
    return y[7:0];
  endfunction

  task automatic model_clear();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        acc_m[r][c] = 32'sd0;
    q.delete();
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                           input logic acc_int, input logic last);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; activations = a; weights = b;
    accumulate_internal = acc_int; in_last = last;
    check("beat_in_ready", {in_ready, in_ready2}, 2'b11);
    @(posedge clk);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        acc_m[r][c] = (acc_int ? acc_m[r][c] : 32'sd0)
                      + $signed(a[(R-1-r)*8 +: 8]) * $signed(b[(C-1-c)*8 +: 8]);
    if (last) begin
      for (int r = 0; r < R; r++) begin
        e.idx = 2'(r);
        e.last = (r == R - 1);
        for (int c = 0; c < C; c++) begin
          e.row0[(C-1-c)*8 +: 8] = rq(acc_m[r][c], 0);
          e.row2[(C-1-c)*8 +: 8] = rq(acc_m[r][c], 2);
        end
        q.push_back(e);
      end
    end
  endtask

  // pat bit (cycle mod 4) is out_ready; junk drives ignored beats during the drain
  task automatic drain(input int nrows, input logic [3:0] pat, input logic junk);
    int got = 0;
    int cyc = 0;
    exp_t e;
    while (got < nrows && cyc < 64) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      in_valid = junk; in_last = 1'b1; accumulate_internal = 1'b1;
      activations = 32'h7f80_7f05; weights = 32'h7f7f_807f;
      check("drain_state", {out_valid, out_valid2, busy, busy2, in_ready, in_ready2}, 6'b111100);
      if (q.size() == 0) begin
        check("queue_nonempty", 64'd0, 64'd1);
      end else begin
        e = q[0];
        check("row_idx", {out_row_idx, out_row_idx2}, {e.idx, e.idx});
        check("row_scale0", out_row, e.row0);
        check("row_scale2", out_row2, e.row2);
        check("row_last", {out_last, out_last2}, {e.last, e.last});
        if (out_ready) begin
          got0[e.idx] = out_row;
          got2[e.idx] = out_row2;
          void'(q.pop_front());
          got++;
        end
      end
      @(posedge clk);
      cyc++;
    end
    check("drain_rows", 64'(got), 64'(nrows));
    if (nrows == R) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      check("post_drain", {in_ready, in_ready2, out_valid, out_valid2, busy, busy2}, 6'b110000);
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, {in_ready, out_valid, out_last, busy, out_row_idx, out_row,
                in_ready2, out_valid2, out_last2, busy2, out_row_idx2, out_row2},
          {1'b1, 3'b000, 2'b00, 32'h0, 1'b1, 3'b000, 2'b00, 32'h0});
  endtask

  initial begin
    arst_n_in = 1'b0; in_valid = 1'b1; in_last = 1'b1; accumulate_internal = 1'b1;
    activations = 32'h0102_0304; weights = 32'h0506_0708; out_ready = 1'b1;
    model_clear();
    repeat (3) begin
      @(negedge clk);
      check_idle("reset_state");
    end
    arst_n_in = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_idle("after_release");

    // Tile of three beats; first beat accumulates onto whatever reset left (zero)
    send_beat(32'h0102_0304, 32'h01ff_0200, 1'b1, 1'b0);
    send_beat(32'h0102_0304, 32'h01ff_0200, 1'b1, 1'b0);
    send_beat(32'h0102_0304, 32'h01ff_0200, 1'b1, 1'b1);
    drain(R, 4'b1111, 1'b0);
    check("tile_row0", got0[0], {8'd3, 8'hfd, 8'd6, 8'd0});
    check("tile_row3", got0[3], {8'd12, 8'hf4, 8'd24, 8'd0});

    // Saturation at scale 0 and 2, with backpressure and ignored beats
    send_beat({8'd127, 8'h80, 8'hff, 8'd5}, {8'd127, 8'd1, 8'hff, 8'd0}, 1'b0, 1'b1);
    drain(R, 4'b1001, 1'b1);
    check("sat_pos_s0", 64'(got0[0][31:24]), 64'h7f);
    check("sat_pos_s2", 64'(got2[0][31:24]), 64'h7f);
    check("sat_neg_s2", 64'(got2[1][31:24]), 64'h80);
    check("floor_neg1_s2", 64'(got2[2][23:16]), 64'hff);

    // Continuation onto the previous tile, then a fresh overwrite
    send_beat(32'h0101_0101, 32'h0101_0101, 1'b1, 1'b1);
    drain(R, 4'b1111, 1'b0);
    send_beat(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b1);
    drain(R, 4'b1101, 1'b0);
    check("overwrite_row3", got0[3], 32'h0101_0101);

    // Reset in the middle of a drain
    send_beat(32'h0102_0304, 32'h01ff_0200, 1'b0, 1'b1);
    drain(2, 4'b1111, 1'b0);
    @(negedge clk);
    arst_n_in = 1'b0; out_ready = 1'b1;
    #1;
    check_idle("reset_mid_drain");
    model_clear();
    @(negedge clk);
    arst_n_in = 1'b1;
    @(negedge clk);
    check_idle("after_mid_reset");
    send_beat(32'h0101_0101, 32'h0101_0101, 1'b1, 1'b1);
    drain(R, 4'b1111, 1'b0);
    check("post_reset_row0", got0[0], 32'h0101_0101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_array_drain.md
# pe_array_drain

Parametrised output-stationary MAC array of ROWS x COLS processing elements with a ready/valid input stream and a row-serial output drain. Each beat broadcasts one activation per row and one weight per column; each PE accumulates its outer-product term. After the tile's last beat the array requantises (shift, saturate) and streams results out one row per handshake, so the downstream writeback needs only a COLS-wide path instead of a full ROWS*COLS bus.

## Interface
- ROWS, 16, array rows (>= 2)
- COLS, 16, array columns (>= 1)
- A_WIDTH, 8, signed activation width
- B_WIDTH, 8, signed weight width
- ACCUMULATOR_WIDTH, 32, signed accumulator width (>= A_WIDTH+B_WIDTH)
- OUTPUT_WIDTH, 8, signed output width (<= ACCUMULATOR_WIDTH)
- OUTPUT_SCALE, 0, arithmetic right shift before saturation (0..ACCUMULATOR_WIDTH-1)

Ports; one clock, asynchronous active-low reset:
- clk  in  1  clock, all state on rising edge
- arst_n_in  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  array can accept a beat (state ACCUM)
- in_last  in  1  qualifies accepted beat as the tile's final beat
- accumulate_internal  in  1  1: add to accumulator; 0: overwrite with product
- activations  in  ROWS*A_WIDTH  row r at [(ROWS-1-r)*A_WIDTH +: A_WIDTH]
- weights  in  COLS*B_WIDTH  column c at [(COLS-1-c)*B_WIDTH +: B_WIDTH]
- out_valid  out  1  drained row valid
- out_ready  in  1  consumer accepts drained row
- out_row  out  COLS*OUTPUT_WIDTH  column c at [(COLS-1-c)*OUTPUT_WIDTH +: OUTPUT_WIDTH]
- out_row_idx  out  $clog2(ROWS)  index of row on out_row
- out_last  out  1  out_valid and out_row_idx == ROWS-1
- busy  out  1  state DRAIN

## Operation
- States: ACCUM (in_ready=1, out_valid=0), DRAIN (in_ready=0, out_valid=1). busy = (state==DRAIN).
- Accept = in_valid && in_ready. On accept, for all r,c: acc[r][c] <= (accumulate_internal ? acc[r][c] : 0) + a[r]*b[c]; product is full signed A_WIDTH+B_WIDTH, sign-extended; sum wraps modulo 2^ACCUMULATOR_WIDTH.
- No accept: accumulators hold. in_valid while in DRAIN is ignored (not accepted, no update).
- Accept with in_last=1: state -> DRAIN, row_ptr=0 on next edge.
- DRAIN: out_row = requant(acc[row_ptr][*]) combinationally from registers; out_row_idx=row_ptr. On out_valid && out_ready: if row_ptr==ROWS-1, state -> ACCUM and row_ptr -> 0; else row_ptr+1. Without out_ready, out_row/out_row_idx hold stable.
- requant(x) = x >>> OUTPUT_SCALE (arithmetic, floor), then saturate to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
- Accumulators are not cleared by a drain; the next tile's first beat uses accumulate_internal=0, or 1 to continue accumulating (partial-sum split across drains is legal).

## Timing
- Reset (arst_n_in low, async): all acc=0, state ACCUM, row_ptr=0; in_ready=1, out_valid=0, out_last=0, busy=0, out_row_idx=0, out_row=0.
- Beat accepted at edge N updates acc at N; visible on out_row from cycle N+1 if it was the last beat.
- Last-beat accept at edge N: out_valid=1 from cycle after N, row 0 presented. Minimum drain ROWS cycles with out_ready held 1; in_ready returns 1 the cycle after the final row handshake.
- Back-to-back: a new beat can be accepted the cycle in_ready rises; no bubble beyond that.
- Reset asserted mid-drain or mid-tile: immediate return to reset state, partial results discarded, no out_valid glitch after deassertion.
- Tile of one beat (in_last on first beat) legal.

## Test plan
- Reset: hold arst_n_in low, drive in_valid=1 -> in_ready=1, out_valid=0, all out_row 0 after release; no acc change while in reset.
- Single tile, ROWS=COLS=4: 3 beats a=[1,2,3,4], b=[1,-1,2,0], first accumulate_internal=0, in_last on 3rd -> rows drained 0..3 with out_row = [3,-3,6,0],[6,-6,12,0],[9,-9,18,0],[12,-12,24,0], out_last on row 3.
- Saturation/scale, OUTPUT_SCALE=2: one beat a=127,b=127 -> 16129>>>2=4032 -> 127; a=-128,b=127 -> -16256>>>2=-4064 -> -128; a=-1,b=1 -> -1>>>2 = -1.
- Backpressure: out_ready toggling 1,0,0,1 during drain -> out_row/out_row_idx stable while stalled, each row exactly once, in_valid during drain ignored (acc unchanged).
- Continuation: drain tile, next tile first beat accumulate_internal=1 a=1,b=1 -> each element = previous + 1; with accumulate_internal=0 -> exactly 1.
- Reset mid-drain after row 1 -> out_valid=0 immediately, acc=0, next tile drains from row 0.
